// File: rtl/video_timing_gen.sv
// Video timing and test-pattern source: hsync/vsync/de plus pixel data with
// burst or free-run operation and frame-boundary enable gating.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE      = 1280,
  parameter int unsigned H_SYNC        = 40,
  parameter int unsigned H_BACK_PORCH  = 220,
  parameter int unsigned H_FRONT_PORCH = 110,
  parameter int unsigned V_ACTIVE      = 720,
  parameter int unsigned V_SYNC        = 5,
  parameter int unsigned V_BACK_PORCH  = 20,
  parameter int unsigned V_FRONT_PORCH = 5,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter bit          SYNC_POL      = 1'b1,
  parameter int unsigned FRAMES        = 0
) (
  input  logic                  sys_clk,
  input  logic                  n_rst,
  input  logic                  en_i,
  input  logic [1:0]            pattern_sel_i,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  frame_start_o,
  output logic                  done_o
);

  localparam int unsigned H_TOTAL     = H_SYNC + H_BACK_PORCH + H_ACTIVE + H_FRONT_PORCH;
  localparam int unsigned V_TOTAL     = V_SYNC + V_BACK_PORCH + V_ACTIVE + V_FRONT_PORCH;
  localparam int unsigned HW          = $clog2(H_TOTAL + 1);
  localparam int unsigned VW          = $clog2(V_TOTAL + 1);
  localparam int unsigned FW          = 16;
  localparam int unsigned H_ACT_START = H_SYNC + H_BACK_PORCH;
  localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int unsigned V_ACT_START = V_SYNC + V_BACK_PORCH;
  localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [1:0]      pat_q, pat_d;

  logic                  hsync_d, vsync_d, de_d, frame_start_d, done_d;
  logic [DATA_WIDTH-1:0] data_d;

  logic [31:0] h32, v32, xw, yw;
  logic        h_last, v_last, h_act, v_act;
  logic [2:0]  bar;

  assign h32    = 32'(h_q);
  assign v32    = 32'(v_q);
  assign xw     = h32 - H_ACT_START;
  assign yw     = v32 - V_ACT_START;
  assign h_last = (h32 == H_TOTAL - 1);
  assign v_last = (v32 == V_TOTAL - 1);
  assign h_act  = (h32 >= H_ACT_START) && (h32 < H_ACT_END);
  assign v_act  = (v32 >= V_ACT_START) && (v32 < V_ACT_END);
  assign bar    = 3'((xw * 32'd8) / H_ACTIVE);

  // Next state: counters, frame count and pattern latch (frame boundaries only)
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    frame_d = frame_q;
    pat_d   = pat_q;
    unique case (state_q)
      StIdle: begin
        frame_d = '0;
        if (en_i) begin
          state_d = StRun;
          h_d     = '0;
          v_d     = '0;
          pat_d   = pattern_sel_i;
        end
      end
      StRun: begin
        if (h_last) begin
          h_d = '0;
          v_d = v_last ? '0 : v_q + VW'(1);
        end else begin
          h_d = h_q + HW'(1);
        end
        if (h_last && v_last) begin
          frame_d = frame_q + FW'(1);
          pat_d   = pattern_sel_i;
          if (FRAMES != 0 && (32'(frame_q) + 32'd1) == FRAMES) begin
            state_d = StDone;
          end else if (!en_i) begin
            state_d = StIdle;
            frame_d = '0;
          end
        end
      end
      StDone: begin
        if (!en_i) begin
          state_d = StIdle;
          frame_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode for the current counter position; registered below
  always_comb begin
    hsync_d       = ~SYNC_POL;
    vsync_d       = ~SYNC_POL;
    de_d          = 1'b0;
    data_d        = '0;
    frame_start_d = 1'b0;
    done_d        = (state_q == StDone);
    if (state_q == StRun) begin
      hsync_d       = (h32 < H_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (v32 < V_SYNC) ? SYNC_POL : ~SYNC_POL;
      frame_start_d = (h_q == '0) && (v_q == '0);
      de_d          = h_act && v_act;
      if (h_act && v_act) begin
        unique case (pat_q)
          2'd0: data_d = DATA_WIDTH'(xw);
          2'd1: data_d = DATA_WIDTH'(bar) << (DATA_WIDTH - 3);
          2'd2: data_d = (((xw ^ yw) & 32'd8) != 32'd0) ? '1 : '0;
          2'd3: data_d = DATA_WIDTH'(frame_q);
          default: data_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= StIdle;
      h_q           <= '0;
      v_q           <= '0;
      frame_q       <= '0;
      pat_q         <= '0;
      hsync_o       <= ~SYNC_POL;
      vsync_o       <= ~SYNC_POL;
      de_o          <= 1'b0;
      data_o        <= '0;
      frame_start_o <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_q       <= frame_d;
      pat_q         <= pat_d;
      hsync_o       <= hsync_d;
      vsync_o       <= vsync_d;
      de_o          <= de_d;
      data_o        <= data_d;
      frame_start_o <= frame_start_d;
      done_o        <= done_d;
    end
  end

endmodule
